sobel_window_gen: RTL and testbench

Streaming 3x3 neighbourhood generator that feeds the Sobel operator. It accepts a raster-order pixel stream of DWIDTH-bit pixels, buffers the two previous image lines, and emits one packed 9-pixel window per interior pixel position. Its output bus is exactly the 72-bit window word the Sobel operator consumes. It sits between the pixel source (FIFO or DMA reader) and the Sobel operator.

---
 rtl/sobel_window_gen_if.sv | 23 ++
 rtl/sobel_window_gen.sv | 112 +++++++++++
 tb/tb_sobel_window_gen.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out streaming bundle for sobel_window_gen.
// The master drives pixels and out_ready; the slave is the window generator.
interface sobel_window_gen_if #(
  parameter int DWIDTH = 8
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DWIDTH-1:0]     in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [9*DWIDTH-1:0]   out;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out, out_last
  );
endinterface

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift register,
// emitting one packed window per interior pixel through a single output register.
module sobel_window_gen #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  parameter int DWIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  sobel_window_gen_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(2);
  localparam logic [RW-1:0] ROW_WIN  = RW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef logic [DWIDTH-1:0] pixel_t;

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [8:0][DWIDTH-1:0] win_q, win_d;
  logic [9*DWIDTH-1:0]   out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;

  pixel_t lb0_mem [WIDTH];
  pixel_t lb1_mem [WIDTH];
  pixel_t lb0_rd, lb1_rd;

  logic in_ready, accept, emit, frame_end;

  assign in_ready  = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  assign lb0_rd    = lb0_mem[col_q];
  assign lb1_rd    = lb1_mem[col_q];
  assign emit      = accept && (row_q >= ROW_WIN) && (col_q >= COL_WIN);
  assign frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Position counters and window shift: slot 3*r+0 is the newest column of row r.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
      end else begin
        col_d = col_q + COL_ONE;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[3*r+2] = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r];
      end
      win_d[0] = lb0_rd;
      win_d[3] = lb1_rd;
      win_d[6] = bus.in_data;
    end
  end

  // Output register: reload on a new window, drop valid once consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_last_d  = out_last_q;
    if (in_ready) begin
      out_valid_d = emit;
    end
    if (emit) begin
      out_d      = win_d;
      out_last_d = frame_end;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // NOTE: line-buffer RAMs are deliberately not reset; the row >= 2 gate keeps stale words out of any window.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb0_mem[col_q] <= lb1_rd;
      lb1_mem[col_q] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: a 4x4 instance for the directed
// scenarios and a 40x30 instance soaked with a random image and random handshakes.
module tb_sobel_window_gen;

  localparam int SW = 4;
  localparam int SH = 4;
  localparam int LW = 40;
  localparam int LH = 30;
  localparam int LN = LW * LH;

  typedef struct packed {
    logic [71:0] win;
    logic        last;
  } exp_t;

  bit   clk = 1'b0;
  logic rst;

  int n_pass  = 0;
  int n_total = 0;

  exp_t        exp_s[$];
  exp_t        exp_l[$];
  logic [71:0] rx_s[$];
  logic        rx_last_s[$];
  exp_t        s_e, l_e;

  logic [7:0]  img [LH][LW];
  int          l_win  = 0;
  int          l_last = 0;
  logic        l_prev_stall = 1'b0;
  logic [71:0] l_prev_out   = '0;

  always #5 clk = ~clk;

  sobel_window_gen_if #(.DWIDTH(8)) s_if ();
  sobel_window_gen_if #(.DWIDTH(8)) l_if ();

  sobel_window_gen #(.WIDTH(SW), .HEIGHT(SH), .DWIDTH(8)) dut_s (
    .clock (clk),
    .reset (rst),
    .bus   (s_if)
  );

  sobel_window_gen #(.WIDTH(LW), .HEIGHT(LH), .DWIDTH(8)) dut_l (
    .clock (clk),
    .reset (rst),
    .bus   (l_if)
  );

  // Reference window for the synthetic image pixel(r,c) = base + r*16 + c.
  function automatic logic [71:0] ref_win(input logic [7:0] base, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++)
      w[k*8 +: 8] = base + 8'((r - 2 + k / 3) * 16 + (c - k % 3));
    return w;
  endfunction

  function automatic logic [71:0] ref_win_l(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++)
      w[k*8 +: 8] = img[r - 2 + k / 3][c - k % 3];
    return w;
  endfunction

  // Small-instance monitor: every handshake pops the scoreboard.
  always @(negedge clk) begin
    if (s_if.out_valid === 1'b1 && s_if.out_ready === 1'b1) begin
      rx_s.push_back(s_if.out);
      rx_last_s.push_back(s_if.out_last);
      n_total++;
      if (exp_s.size() == 0) begin
        $display("FAIL s_unexpected_window got=%h last=%b expected none", s_if.out, s_if.out_last);
      end else begin
        s_e = exp_s.pop_front();
        if (s_if.out !== s_e.win || s_if.out_last !== s_e.last)
          $display("FAIL s_window got=%h last=%b expected=%h last=%b",
                   s_if.out, s_if.out_last, s_e.win, s_e.last);
        else
          n_pass++;
      end
    end
  end

  // Large-instance monitor: scoreboard plus hold-stable check while stalled.
  always @(negedge clk) begin
    if (l_prev_stall) begin
      n_total++;
      if (l_if.out_valid !== 1'b1 || l_if.out !== l_prev_out)
        $display("FAIL l_hold got=%h valid=%b expected=%h valid=1", l_if.out, l_if.out_valid, l_prev_out);
      else
        n_pass++;
    end
    if (l_if.out_valid === 1'b1 && l_if.out_ready === 1'b1) begin
      l_win++;
      if (l_if.out_last === 1'b1) l_last++;
      n_total++;
      if (exp_l.size() == 0) begin
        $display("FAIL l_unexpected_window got=%h expected none", l_if.out);
      end else begin
        l_e = exp_l.pop_front();
        if (l_if.out !== l_e.win || l_if.out_last !== l_e.last)
          $display("FAIL l_window got=%h last=%b expected=%h last=%b",
                   l_if.out, l_if.out_last, l_e.win, l_e.last);
        else
          n_pass++;
      end
    end
    l_prev_stall = (l_if.out_valid === 1'b1) && (l_if.out_ready === 1'b0);
    l_prev_out   = l_if.out;
  end

  // Entered and left at posedge+1; pushes the expected window when the pixel is taken.
  task automatic send_px(input logic [7:0] base, input int r, input int c);
    int guard;
    exp_t e;
    s_if.in_valid = 1'b1;
    s_if.in_data  = base + 8'(r * 16 + c);
    guard = 0;
    @(negedge clk);
    while (s_if.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_total++;
      $display("FAIL s_accept_timeout in_ready=%b expected=1", s_if.in_ready);
    end else if (r >= 2 && c >= 2) begin
      e.win  = ref_win(base, r, c);
      e.last = (r == SH - 1) && (c == SW - 1);
      exp_s.push_back(e);
    end
    @(posedge clk); #1;
    s_if.in_valid = 1'b0;
  endtask

  task automatic drain_s;
    int g;
    g = 0;
    while (exp_s.size() != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_total++;
    if (exp_s.size() != 0)
      $display("FAIL s_drain pending=%0d expected=0", exp_s.size());
    else
      n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_total++;
    if (s_if.out_valid !== 1'b0 || s_if.out !== 72'h0 || s_if.out_last !== 1'b0)
      $display("FAIL reset_outputs valid=%b out=%h last=%b expected 0/0/0",
               s_if.out_valid, s_if.out, s_if.out_last);
    else
      n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (s_if.in_ready !== 1'b1)
      $display("FAIL reset_in_ready got=%b expected=1", s_if.in_ready);
    else
      n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    rx_s.delete();
    rx_last_s.delete();
    for (int i = 0; i < SW * SH; i++) begin
      send_px(8'h00, i / SW, i % SW);
      if (i == 2 * SW + 2) begin
        @(negedge clk);
        n_total++;
        if (s_if.out_valid !== 1'b1 || s_if.out !== 72'h20_21_22_10_11_12_00_01_02)
          $display("FAIL basic_first_latency valid=%b out=%h expected valid=1 out=%h",
                   s_if.out_valid, s_if.out, 72'h20_21_22_10_11_12_00_01_02);
        else
          n_pass++;
        @(posedge clk); #1;
      end
    end
    drain_s();
    n_total++;
    if (rx_s.size() != 4)
      $display("FAIL basic_count got=%0d expected=4", rx_s.size());
    else
      n_pass++;
    if (rx_s.size() == 4) begin
      n_total++;
      if (rx_s[3] !== 72'h31_32_33_21_22_23_11_12_13 || rx_last_s[3] !== 1'b1 ||
          rx_last_s[0] !== 1'b0 || rx_last_s[2] !== 1'b0)
        $display("FAIL basic_last got=%h last=%b expected=%h last=1",
                 rx_s[3], rx_last_s[3], 72'h31_32_33_21_22_23_11_12_13);
      else
        n_pass++;
    end
  endtask

  task automatic test_backpressure;
    rx_s.delete();
    rx_last_s.delete();
    for (int i = 0; i <= 2 * SW + 2; i++) send_px(8'h00, i / SW, i % SW);
    s_if.out_ready = 1'b0;
    s_if.in_valid  = 1'b1;
    s_if.in_data   = 8'h23;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if (s_if.out_valid !== 1'b1 || s_if.out !== ref_win(8'h00, 2, 2) || s_if.in_ready !== 1'b0)
        $display("FAIL bp_hold cycle=%0d valid=%b out=%h in_ready=%b expected valid=1 out=%h in_ready=0",
                 k, s_if.out_valid, s_if.out, s_if.in_ready, ref_win(8'h00, 2, 2));
      else
        n_pass++;
      @(posedge clk); #1;
    end
    s_if.out_ready = 1'b1;
    for (int i = 2 * SW + 3; i < SW * SH; i++) send_px(8'h00, i / SW, i % SW);
    drain_s();
    n_total++;
    if (rx_s.size() != 4)
      $display("FAIL bp_count got=%0d expected=4", rx_s.size());
    else
      n_pass++;
  endtask

  task automatic test_gaps;
    int k;
    rx_s.delete();
    rx_last_s.delete();
    for (int i = 0; i < SW * SH; i++) begin
      k = 0;
      while (k < 8 && $urandom_range(1) == 0) begin
        @(posedge clk); #1;
        k++;
      end
      send_px(8'h00, i / SW, i % SW);
    end
    drain_s();
    n_total++;
    if (rx_s.size() != 4)
      $display("FAIL gaps_count got=%0d expected=4", rx_s.size());
    else
      n_pass++;
    for (int i = 0; i < 4 && i < rx_s.size(); i++) begin
      n_total++;
      if (rx_s[i] !== ref_win(8'h00, 2 + i / 2, 2 + i % 2) || rx_last_s[i] !== (i == 3))
        $display("FAIL gaps_window idx=%0d got=%h last=%b expected=%h",
                 i, rx_s[i], rx_last_s[i], ref_win(8'h00, 2 + i / 2, 2 + i % 2));
      else
        n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    rx_s.delete();
    rx_last_s.delete();
    for (int i = 0; i < 2 * SW * SH; i++)
      send_px((i < SW * SH) ? 8'h00 : 8'h80, (i / SW) % SH, i % SW);
    drain_s();
    n_total++;
    if (rx_s.size() != 8)
      $display("FAIL b2b_count got=%0d expected=8", rx_s.size());
    else
      n_pass++;
    if (rx_s.size() == 8) begin
      n_total++;
      if (rx_s[4] !== 72'hA0_A1_A2_90_91_92_80_81_82 || rx_last_s[3] !== 1'b1 || rx_last_s[7] !== 1'b1)
        $display("FAIL b2b_frame2_first got=%h lasts=%b/%b expected=%h lasts=1/1",
                 rx_s[4], rx_last_s[3], rx_last_s[7], 72'hA0_A1_A2_90_91_92_80_81_82);
      else
        n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 0; i < 6; i++) send_px(8'h00, i / SW, i % SW);
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (s_if.out_valid !== 1'b0 || s_if.out !== 72'h0 || s_if.out_last !== 1'b0)
      $display("FAIL midreset_outputs valid=%b out=%h last=%b expected 0/0/0",
               s_if.out_valid, s_if.out, s_if.out_last);
    else
      n_pass++;
    rst = 1'b0;
    rx_s.delete();
    rx_last_s.delete();
    for (int i = 0; i < SW * SH; i++) send_px(8'h00, i / SW, i % SW);
    drain_s();
    n_total++;
    if (rx_s.size() != 4 || rx_s[0] !== 72'h20_21_22_10_11_12_00_01_02)
      $display("FAIL midreset_frame count=%0d first=%h expected count=4 first=%h",
               rx_s.size(), (rx_s.size() > 0) ? rx_s[0] : 72'h0, 72'h20_21_22_10_11_12_00_01_02);
    else
      n_pass++;
  endtask

  task automatic test_soak;
    int idx, r, c;
    bit done;
    exp_t e;
    for (int y = 0; y < LH; y++)
      for (int x = 0; x < LW; x++)
        img[y][x] = 8'($urandom_range(255));
    idx    = 0;
    done   = 1'b0;
    l_win  = 0;
    l_last = 0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(posedge clk); #1;
      l_if.out_ready = ($urandom_range(3) != 0);
      r = idx / LW;
      c = idx % LW;
      if (idx < LN) begin
        l_if.in_valid = ($urandom_range(3) != 0);
        l_if.in_data  = img[r][c];
      end else begin
        l_if.in_valid = 1'b0;
      end
      @(negedge clk);
      if (l_if.in_valid === 1'b1 && l_if.in_ready === 1'b1) begin
        if (r >= 2 && c >= 2) begin
          e.win  = ref_win_l(r, c);
          e.last = (r == LH - 1) && (c == LW - 1);
          exp_l.push_back(e);
        end
        idx++;
      end
      if (idx == LN && exp_l.size() == 0) done = 1'b1;
    end
    @(posedge clk); #1;
    l_if.in_valid  = 1'b0;
    l_if.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_total++;
    if (idx != LN || exp_l.size() != 0)
      $display("FAIL soak_progress accepted=%0d pending=%0d expected accepted=%0d pending=0",
               idx, exp_l.size(), LN);
    else
      n_pass++;
    n_total++;
    if (l_win != (LW - 2) * (LH - 2) || l_last != 1)
      $display("FAIL soak_count windows=%0d lasts=%0d expected windows=%0d lasts=1",
               l_win, l_last, (LW - 2) * (LH - 2));
    else
      n_pass++;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    s_if.in_valid  = 1'b0;
    s_if.in_data   = '0;
    s_if.out_ready = 1'b1;
    l_if.in_valid  = 1'b0;
    l_if.in_data   = '0;
    l_if.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_soak();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
